dsp_t1_mult_arbiter: RTL and testbench

DSP_T1_MULT_ARBITER -- requirements
Module: dsp_t1_mult_arbiter

---
 rtl/dsp_t1_mult_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/dsp_t1_mult_arbiter.sv | 95 +++++++++
 tb/tb_dsp_t1_mult_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_t1_mult_pkg.sv
// Shared widths, constants and tag type for the DSP multiplier arbiter.
// Covers the 20x18 multiply mode of the DSP cell.
package dsp_t1_mult_pkg;
   localparam int A_W = 20;
   localparam int B_W = 18;
   localparam int Z_W = 38;
   localparam int ID_MAX_W = 3;
   localparam logic [2:0] FEEDBACK_MULT = 3'b000;

   typedef struct packed {
      logic                valid;
      logic [ID_MAX_W-1:0] id;
   } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant logic with a rotating priority pointer.
// The pointer moves past the winner only when advance is high.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       advance,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       grant_any
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W:0]   k;

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      grant     = '0;
      k         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = {1'b0, ptr} + (IDX_W+1)'(i);
         if (k >= (IDX_W+1)'(NUM_REQ))
            k = k - (IDX_W+1)'(NUM_REQ);
         if (!grant_any && req[k[IDX_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = k[IDX_W-1:0];
         end
      end
      if (grant_any)
         grant = NUM_REQ'(1) << grant_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (advance)
         ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
   end
endmodule

// File: rtl/dsp_t1_mult_arbiter.sv
// Shares one DSP multiplier among NUM_REQ requesters and returns tagged
// products in issue order, one per cycle at full throughput.
import dsp_t1_mult_pkg::*;

module dsp_t1_mult_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 1
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       enable_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic [NUM_REQ*A_W-1:0]     req_a_i,
   input  logic [NUM_REQ*B_W-1:0]     req_b_i,
   input  logic [NUM_REQ-1:0]         req_unsigned_a_i,
   input  logic [NUM_REQ-1:0]         req_unsigned_b_i,
   output logic [A_W-1:0]             dsp_a_o,
   output logic [B_W-1:0]             dsp_b_o,
   output logic                       dsp_unsigned_a_o,
   output logic                       dsp_unsigned_b_o,
   output logic [2:0]                 dsp_feedback_o,
   input  logic [Z_W-1:0]             dsp_z_i,
   output logic                       rsp_valid_o,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
   output logic [Z_W-1:0]             rsp_z_o,
   output logic                       busy_o,
   output logic [15:0]                issue_count_o
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req_gated;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   tag_t               tag_in;
   tag_t               tag_q [LATENCY+1];

   // Ready is only ever raised on a valid requester, so a grant is a handshake.
   assign req_gated = req_valid_i & {NUM_REQ{enable_i & ~reset_i}};

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .clk       (clock_i),
      .rst       (reset_i),
      .req       (req_gated),
      .advance   (win_any),
      .grant     (req_ready_o),
      .grant_idx (win_idx),
      .grant_any (win_any)
   );

   always_comb begin
      dsp_a_o          = '0;
      dsp_b_o          = '0;
      dsp_unsigned_a_o = 1'b0;
      dsp_unsigned_b_o = 1'b0;
      if (win_any) begin
         dsp_a_o          = req_a_i[int'(win_idx)*A_W +: A_W];
         dsp_b_o          = req_b_i[int'(win_idx)*B_W +: B_W];
         dsp_unsigned_a_o = req_unsigned_a_i[win_idx];
         dsp_unsigned_b_o = req_unsigned_b_i[win_idx];
      end
   end

   assign dsp_feedback_o = FEEDBACK_MULT;

   assign tag_in.valid = win_any;
   assign tag_in.id    = ID_MAX_W'(win_idx);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i <= LATENCY; i++)
            tag_q[i] <= '0;
         rsp_z_o       <= '0;
         issue_count_o <= '0;
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i <= LATENCY; i++)
            tag_q[i] <= tag_q[i-1];
         rsp_z_o <= dsp_z_i;
         if (win_any)
            issue_count_o <= issue_count_o + 16'd1;
      end
   end

   assign rsp_valid_o = tag_q[LATENCY].valid;
   assign rsp_id_o    = tag_q[LATENCY].id[IDX_W-1:0];

   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i <= LATENCY; i++)
         busy_o = busy_o | tag_q[i].valid;
   end
endmodule

// File: tb/tb_dsp_t1_mult_arbiter.sv
// Bench for dsp_t1_mult_arbiter with a registered-input DSP multiplier model
// and a queue-based reference of grants, products and response timing.
module tb_dsp_t1_mult_arbiter;
   localparam int NR  = 4;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [NR-1:0] valid;
   logic [NR-1:0] ready;
   logic [NR*20-1:0] a_bus;
   logic [NR*18-1:0] b_bus;
   logic [NR-1:0] ua, ub;
   logic [19:0]   dsp_a;
   logic [17:0]   dsp_b;
   logic          dsp_ua, dsp_ub;
   logic [2:0]    fb;
   logic [37:0]   dsp_z;
   logic          rsp_valid;
   logic [1:0]    rsp_id;
   logic [37:0]   rsp_z;
   logic          busy;
   logic [15:0]   cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dsp_t1_mult_arbiter #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
      .clock_i          (clk),
      .reset_i          (rst),
      .enable_i         (en),
      .req_valid_i      (valid),
      .req_ready_o      (ready),
      .req_a_i          (a_bus),
      .req_b_i          (b_bus),
      .req_unsigned_a_i (ua),
      .req_unsigned_b_i (ub),
      .dsp_a_o          (dsp_a),
      .dsp_b_o          (dsp_b),
      .dsp_unsigned_a_o (dsp_ua),
      .dsp_unsigned_b_o (dsp_ub),
      .dsp_feedback_o   (fb),
      .dsp_z_i          (dsp_z),
      .rsp_valid_o      (rsp_valid),
      .rsp_id_o         (rsp_id),
      .rsp_z_o          (rsp_z),
      .busy_o           (busy),
      .issue_count_o    (cnt)
   );

   // DSP cell stand-in: operands registered, product combinational.
   logic [19:0] ra;
   logic [17:0] rb;
   logic        rua, rub;
   logic signed [20:0] sa;
   logic signed [18:0] sb;
   logic signed [39:0] sp;
   always @(posedge clk) begin
      ra  <= dsp_a;
      rb  <= dsp_b;
      rua <= dsp_ua;
      rub <= dsp_ub;
   end
   assign sa    = {~rua & ra[19], ra};
   assign sb    = {~rub & rb[17], rb};
   assign sp    = sa * sb;
   assign dsp_z = sp[37:0];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [37:0] ref_prod(input logic [19:0] a,
      input logic [17:0] b, input logic u_a, input logic u_b);
      longint va, vb, p;
      va = longint'(a);
      vb = longint'(b);
      if (!u_a && a[19]) va = va - (longint'(1) << 20);
      if (!u_b && b[17]) vb = vb - (longint'(1) << 18);
      p = va * vb;
      return p[37:0];
   endfunction

   typedef struct {
      int          due;
      int          id;
      logic [37:0] z;
   } exp_t;

   exp_t q[$];
   int   m_ptr = 0;
   int   m_cnt = 0;
   int   smp   = 0;

   always @(negedge clk) begin : compare
      int         w;
      int         kk;
      logic [NR-1:0] er;
      smp++;
      if (rst) begin
         q.delete();
         m_ptr = 0;
         m_cnt = 0;
         check("rst_ready", 64'(ready), 0);
         check("rst_rsp_valid", 64'(rsp_valid), 0);
         check("rst_rsp_id", 64'(rsp_id), 0);
         check("rst_rsp_z", 64'(rsp_z), 0);
         check("rst_busy", 64'(busy), 0);
         check("rst_count", 64'(cnt), 0);
      end else begin
         w = -1;
         if (en)
            for (int i = 0; i < NR; i++) begin
               kk = (m_ptr + i) % NR;
               if (w < 0 && valid[kk]) w = kk;
            end
         er = (w >= 0) ? (NR'(1) << w) : '0;
         check("ready", 64'(ready), 64'(er));
         check("dsp_a", 64'(dsp_a), (w >= 0) ? 64'(a_bus[w*20 +: 20]) : 0);
         check("dsp_b", 64'(dsp_b), (w >= 0) ? 64'(b_bus[w*18 +: 18]) : 0);
         check("dsp_ua", 64'(dsp_ua), (w >= 0) ? 64'(ua[w]) : 0);
         check("dsp_ub", 64'(dsp_ub), (w >= 0) ? 64'(ub[w]) : 0);
         check("feedback", 64'(fb), 0);
         check("count", 64'(cnt), 64'(m_cnt));
         check("busy", 64'(busy), 64'(q.size() != 0));
         if (q.size() != 0 && q[0].due == smp) begin
            check("rsp_valid", 64'(rsp_valid), 1);
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            check("rsp_z", 64'(rsp_z), 64'(q[0].z));
            void'(q.pop_front());
         end else begin
            check("rsp_valid_idle", 64'(rsp_valid), 0);
         end
         if (w >= 0) begin
            q.push_back('{smp + LAT + 1, w,
               ref_prod(a_bus[w*20 +: 20], b_bus[w*18 +: 18], ua[w], ub[w])});
            m_ptr = (w + 1) % NR;
            m_cnt = (m_cnt + 1) & 16'hFFFF;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic single(input int k, input logic [19:0] a,
      input logic [17:0] b, input logic u_a, input logic u_b,
      input logic [37:0] ez);
      tick();
      valid = '0;
      valid[k] = 1'b1;
      a_bus[k*20 +: 20] = a;
      b_bus[k*18 +: 18] = b;
      ua[k] = u_a;
      ub[k] = u_b;
      @(negedge clk);
      check("single_ready", 64'(ready), 64'(NR'(1) << k));
      tick();
      valid = '0;
      repeat (LAT + 1) @(negedge clk);
      check("single_rsp_valid", 64'(rsp_valid), 1);
      check("single_rsp_id", 64'(rsp_id), 64'(k));
      check("single_rsp_z", 64'(rsp_z), 64'(ez));
   endtask

   function automatic logic [19:0] pick_a();
      case ($urandom % 5)
         0: return 20'h80000;
         1: return 20'hFFFFF;
         2: return 20'h7FFFF;
         default: return 20'($urandom);
      endcase
   endfunction

   function automatic logic [17:0] pick_b();
      case ($urandom % 5)
         0: return 18'h20000;
         1: return 18'h3FFFF;
         2: return 18'h1FFFF;
         default: return 18'($urandom);
      endcase
   endfunction

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int got_id[$];
      int first_j, last_j, nrsp;
      logic [NR-1:0] gr [8];

      rst   = 1'b1;
      en    = 1'b1;
      valid = '1;
      a_bus = '0;
      b_bus = '0;
      ua    = '0;
      ub    = '0;
      @(negedge clk);
      check("reset_ready_zero", 64'(ready), 0);
      check("reset_count_zero", 64'(cnt), 0);
      tick();
      valid = '0;
      rst   = 1'b0;

      single(2, 20'hFFFFD, 18'd7, 1'b0, 1'b0, 38'h3FFFFFFFEB);
      single(0, 20'hFFFFF, 18'h3FFFF, 1'b1, 1'b1, 38'h3FFFEC0001);
      single(1, 20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 38'd1);
      single(3, 20'd1000, 18'h3FFFB, 1'b0, 1'b0, 38'h3FFFFFEC78);
      single(0, 20'd123, 18'd456, 1'b1, 1'b1, 38'd56088);
      tick();
      valid = '1;
      @(negedge clk);
      check("ptr_after_wrap", 64'(ready), 64'(4'b0010));
      tick();
      valid = '0;

      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < NR; k++) begin
         a_bus[k*20 +: 20] = pick_a();
         b_bus[k*18 +: 18] = pick_b();
      end
      ua = 4'b0101;
      ub = 4'b0011;
      first_j = -1;
      last_j  = -1;
      for (int j = 0; j < 8 + LAT + 2; j++) begin
         valid = (j < 8) ? '1 : '0;
         @(negedge clk);
         if (j < 8) gr[j] = ready;
         if (rsp_valid) begin
            got_id.push_back(int'(rsp_id));
            if (first_j < 0) first_j = j;
            last_j = j;
         end
         tick();
      end
      for (int i = 0; i < 8; i++)
         check("rr_grant_order", 64'(gr[i]), 64'(NR'(1) << (i % 4)));
      check("rr_rsp_count", 64'(got_id.size()), 8);
      for (int i = 0; i < got_id.size(); i++)
         check("rr_rsp_id_order", 64'(got_id[i]), 64'(i % 4));
      check("rr_rsp_back_to_back", 64'(last_j - first_j), 7);
      check("rr_issue_count", 64'(cnt), 8);

      nrsp = 0;
      for (int j = 0; j < 6; j++) begin
         en    = (j < 2);
         valid = 4'b0011;
         @(negedge clk);
         if (j >= 2) check("enable_low_ready", 64'(ready), 0);
         if (rsp_valid) nrsp++;
         if (j == 5) check("enable_busy_fall", 64'(busy), 0);
         tick();
      end
      check("enable_inflight_done", 64'(nrsp), 2);
      valid = '0;
      en    = 1'b1;

      nrsp = 0;
      for (int j = 0; j < 7; j++) begin
         valid = (j < 2) ? 4'b1100 : 4'b0000;
         rst   = (j == 2);
         @(negedge clk);
         if (j >= 2 && rsp_valid) nrsp++;
         tick();
      end
      check("reset_discard_rsp", 64'(nrsp), 0);
      check("reset_discard_count", 64'(cnt), 0);
      valid = '1;
      @(negedge clk);
      check("reset_ptr_zero", 64'(ready), 64'(4'b0001));
      tick();
      valid = '0;

      for (int c = 0; c < 400; c++) begin
         rst   = ($urandom % 100) == 0;
         en    = ($urandom % 8) != 0;
         valid = NR'($urandom);
         ua    = NR'($urandom);
         ub    = NR'($urandom);
         for (int k = 0; k < NR; k++) begin
            a_bus[k*20 +: 20] = pick_a();
            b_bus[k*18 +: 18] = pick_b();
         end
         tick();
      end
      rst   = 1'b0;
      valid = '0;
      repeat (LAT + 4) tick();
      @(negedge clk);
      check("final_idle_busy", 64'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
